// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the memory controller.
//   mc_state_e  - controller FSM states (MC_IDLE, MC_IF_READ, MC_LS_READ, MC_LS_WRITE)
//   SZ_B/SZ_H/SZ_W - lsb_size[1:0] codes for byte, half and word accesses
//   IO_MASK_DEF - default address bits that, when all set, mark an IO access
//   last_cnt()  - index of the final byte (N-1) for a size code
//   extend()    - sign/zero extension of an assembled load value
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MC_IDLE     = 2'd0,
    MC_IF_READ  = 2'd1,
    MC_LS_READ  = 2'd2,
    MC_LS_WRITE = 2'd3
  } mc_state_e;

  localparam logic [1:0]  SZ_B = 2'b00;
  localparam logic [1:0]  SZ_H = 2'b01;
  localparam logic [1:0]  SZ_W = 2'b10;
  localparam logic [31:0] IO_MASK_DEF = 32'h0003_0000;

  // Unused code 2'b11 is treated as a word access.
  function automatic logic [1:0] last_cnt(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 2'd0;
      SZ_H:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // size[2] = 1 selects zero extension, otherwise sign extension.
  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] size);
    logic [31:0] r;
    case (size[1:0])
      SZ_B:    r = {{24{~size[2] & raw[7]}}, raw[7:0]};
      SZ_H:    r = {{16{~size[2] & raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction fetch and the load/store buffer onto a
// byte-wide RAM/IO port, serialising each access into 1, 2 or 4 byte
// transfers and returning one 32-bit result with a one-cycle ready pulse.
//
// Optional feature: define MEM_CTRL_IO_STALL_EN to hold a store to an IO
// address (all IO_MASK bits set) while io_buffer_full is high.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global enable; low freezes all state, blocks writes
//   mem_din           RAM read data (byte for the address of the previous cycle)
//   mem_dout/mem_a/mem_wr  byte bus towards RAM/IO (0 when idle)
//   io_buffer_full    UART buffer full (used only with MEM_CTRL_IO_STALL_EN)
//   clear             mispredict flush; aborts fetches only
//   if_req/if_addr    fetch request   -> if_ready pulse, if_inst word
//   lsb_req/lsb_size/lsb_way/lsb_addr/lsb_value  load/store request
//                     -> lsb_ready pulse, lsb_result (0 for stores)
//   fsm_state         current FSM state, for observation
//
// Handshake: requests are levels sampled in MC_IDLE; lsb_req wins over
// if_req, clear blocks if_req, and nothing is accepted while either ready
// pulse is high. A request accepted at the end of cycle T drives its first
// byte in T+1; ready is high for exactly one cycle in T+N+1, and the result
// is valid in that cycle and holds until the next pulse of that port.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                 ADDR_W  = 32,
  parameter logic [ADDR_W-1:0]  IO_MASK = ADDR_W'(IO_MASK_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_inst,
  input  logic              lsb_req,
  input  logic [2:0]        lsb_size,
  input  logic              lsb_way,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_value,
  output logic              lsb_ready,
  output logic [31:0]       lsb_result,
  output mc_state_e         fsm_state
);

  mc_state_e         state;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] base;
  logic [2:0]        size_q;
  logic              way_q;
  logic [31:0]       value_q;
  logic [23:0]       rbuf;        // bytes 0..2 captured so far
  logic              if_ready_q;
  logic              lsb_ready_q;
  logic [31:0]       inst_hold;
  logic [31:0]       result_hold;

  logic [1:0]        last;
  logic              is_io;
  logic              stall;
  logic [31:0]       raw;
  logic [31:0]       lsb_val;

  assign last      = last_cnt(size_q[1:0]);
  assign is_io     = (base & IO_MASK) == IO_MASK;
  assign fsm_state = state;

`ifdef MEM_CTRL_IO_STALL_EN
  assign stall = (state == MC_LS_WRITE) && is_io && io_buffer_full;
`else
  logic unused_io;
  assign stall     = 1'b0;
  assign unused_io = io_buffer_full ^ is_io;
`endif

  // The final byte is still on mem_din during the ready cycle, so the
  // result is assembled from the captured bytes plus mem_din, then held.
  always_comb begin
    raw = {mem_din, rbuf};
    case (size_q[1:0])
      SZ_B:    raw = {24'h0, mem_din};
      SZ_H:    raw = {16'h0, mem_din, rbuf[7:0]};
      default: raw = {mem_din, rbuf};
    endcase
    lsb_val = way_q ? 32'h0 : extend(raw, size_q);
  end

  assign if_ready   = if_ready_q;
  assign lsb_ready  = lsb_ready_q;
  assign if_inst    = if_ready_q  ? raw     : inst_hold;
  assign lsb_result = lsb_ready_q ? lsb_val : result_hold;

  // Bus drive is decoded from registered state; mem_wr is gated by rdy
  // and the IO stall so a frozen cycle never repeats a write.
  always_comb begin
    mem_a    = '0;
    mem_dout = 8'h00;
    mem_wr   = 1'b0;
    if (state != MC_IDLE) begin
      mem_a = base + ADDR_W'(cnt);
      if (state == MC_LS_WRITE) begin
        mem_dout = value_q[{cnt, 3'b000} +: 8];
        mem_wr   = rdy & ~stall;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MC_IDLE;
      cnt         <= 2'd0;
      base        <= '0;
      size_q      <= 3'b000;
      way_q       <= 1'b0;
      value_q     <= 32'h0;
      rbuf        <= 24'h0;
      if_ready_q  <= 1'b0;
      lsb_ready_q <= 1'b0;
      inst_hold   <= 32'h0;
      result_hold <= 32'h0;
    end else if (rdy) begin
      if_ready_q  <= 1'b0;
      lsb_ready_q <= 1'b0;
      if (if_ready_q)  inst_hold   <= raw;
      if (lsb_ready_q) result_hold <= lsb_val;
      case (state)
        MC_IDLE: begin
          if (!if_ready_q && !lsb_ready_q) begin
            if (lsb_req) begin
              base    <= lsb_addr;
              size_q  <= lsb_size;
              way_q   <= lsb_way;
              value_q <= lsb_value;
              cnt     <= 2'd0;
              state   <= lsb_way ? MC_LS_WRITE : MC_LS_READ;
            end else if (if_req && !clear) begin
              base   <= if_addr;
              size_q <= {1'b0, SZ_W};
              way_q  <= 1'b0;
              cnt    <= 2'd0;
              state  <= MC_IF_READ;
            end
          end
        end
        MC_IF_READ, MC_LS_READ: begin
          // mem_din now holds the byte addressed in the previous cycle.
          case (cnt)
            2'd1:    rbuf[7:0]   <= mem_din;
            2'd2:    rbuf[15:8]  <= mem_din;
            2'd3:    rbuf[23:16] <= mem_din;
            default: ;
          endcase
          if (state == MC_IF_READ && clear) begin
            state <= MC_IDLE;
            cnt   <= 2'd0;
          end else if (cnt == last) begin
            state <= MC_IDLE;
            cnt   <= 2'd0;
            if (state == MC_IF_READ) if_ready_q  <= 1'b1;
            else                     lsb_ready_q <= 1'b1;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        MC_LS_WRITE: begin
          if (!stall) begin
            if (cnt == last) begin
              state       <= MC_IDLE;
              cnt         <= 2'd0;
              lsb_ready_q <= 1'b1;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        default: state <= MC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized bench for mem_ctrl with a byte RAM
// (one-cycle read latency) and a reference memory image kept in the bench.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk, rst, rdy, io_buffer_full, clear;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a, if_addr, if_inst, lsb_addr, lsb_value, lsb_result;
  logic        mem_wr, if_req, if_ready, lsb_req, lsb_way, lsb_ready;
  logic [2:0]  lsb_size;
  mc_state_e   fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_mem [0:4095];
  logic [7:0] ram     [0:4095];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
    .clear(clear), .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_inst(if_inst), .lsb_req(lsb_req), .lsb_size(lsb_size), .lsb_way(lsb_way),
    .lsb_addr(lsb_addr), .lsb_value(lsb_value), .lsb_ready(lsb_ready),
    .lsb_result(lsb_result), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model (4 KiB image, addresses alias mod 4096) ----------------
  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 29) ^ (i >> 5) ^ 32'h5a);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_byte(i);
      mem_din <= 8'h00;
    end else begin
      if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
      mem_din <= ram[mem_a[11:0]];
    end
  end

  // ---------------- reference model ----------------
  task automatic ref_reset();
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input int n, input bit zext);
    longint v;
    v = 0;
    for (int i = 0; i < n; i++)
      v += longint'(ref_mem[12'(addr + 32'(i))]) << (8 * i);
    if (!zext && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n)) + (longint'(1) << 32);
    return v[31:0];
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one complete transaction ----------------
  // clr_at: raise clear in that byte cycle (0 = never).
  // frz_at: insert two rdy-low cycles before that byte cycle (stores only).
  task automatic txn(input bit is_if, input bit way, input logic [2:0] size,
                     input logic [31:0] addr, input logic [31:0] value,
                     input int clr_at, input int frz_at);
    int n;
    logic [31:0] exp;
    bit aborted;
    bit st;
    st = !is_if && way;
    n = is_if ? 4 : (size[1:0] == 2'b00 ? 1 : (size[1:0] == 2'b01 ? 2 : 4));
    if (is_if)   exp = ref_load(addr, 4, 1'b1);
    else if (st) exp = 32'h0;
    else         exp = ref_load(addr, n, size[2]);
    if (st) for (int i = 0; i < n; i++) ref_mem[12'(addr + 32'(i))] = value[8*i +: 8];

    @(posedge clk); #1;
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      lsb_req = 1'b1; lsb_way = way; lsb_size = size; lsb_addr = addr; lsb_value = value;
    end
    @(posedge clk); #1;
    if_req = 1'b0; lsb_req = 1'b0;
    aborted = 1'b0;
    for (int k = 1; k <= n; k++) begin
      if (k == frz_at) begin
        rdy = 1'b0;
        for (int f = 0; f < 2; f++) begin
          @(negedge clk);
          check("frz_wr", 32'(mem_wr), 32'h0);
          check("frz_a", mem_a, addr + 32'(k - 1));
          @(posedge clk); #1;
        end
        rdy = 1'b1;
      end
      clear = (k == clr_at);
      @(negedge clk);
      check("addr", mem_a, addr + 32'(k - 1));
      check("wr", 32'(mem_wr), 32'(st));
      if (st) check("dout", 32'(mem_dout), 32'(value[8*(k-1) +: 8]));
      check("busy_no_rdy", 32'({if_ready, lsb_ready}), 32'h0);
      @(posedge clk); #1;
      clear = 1'b0;
      if (k == clr_at && is_if) begin
        aborted = 1'b1;
        break;
      end
    end
    @(negedge clk);
    if (aborted) begin
      check("abort_idle_a", mem_a, 32'h0);
      for (int j = 0; j < 4; j++) begin
        check("abort_no_rdy", 32'(if_ready), 32'h0);
        @(negedge clk);
      end
    end else if (is_if) begin
      check("if_rdy", 32'(if_ready), 32'h1);
      check("if_inst", if_inst, exp);
      check("idle_in_rdy", 32'(fsm_state), 32'(MC_IDLE));
      @(negedge clk);
      check("if_pulse", 32'(if_ready), 32'h0);
      check("if_hold", if_inst, exp);
    end else begin
      check("lsb_rdy", 32'(lsb_ready), 32'h1);
      check("lsb_res", lsb_result, exp);
      check("idle_in_rdy", 32'(fsm_state), 32'(MC_IDLE));
      @(negedge clk);
      check("lsb_pulse", 32'(lsb_ready), 32'h0);
      check("lsb_hold", lsb_result, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; clear = 1'b0;
    if_req = 1'b0; if_addr = 32'h0; lsb_req = 1'b0; lsb_way = 1'b0;
    lsb_size = 3'b000; lsb_addr = 32'h0; lsb_value = 32'h0;
    ref_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_mem_dout", 32'(mem_dout), 32'h0);
    check("rst_readies", 32'({if_ready, lsb_ready}), 32'h0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_lsb_result", lsb_result, 32'h0);
    check("rst_state", 32'(fsm_state), 32'(MC_IDLE));

    // word store then word load at 0x100
    txn(0, 1, 3'b010, 32'h100, 32'h1234_5678, 0, 0);
    txn(0, 0, 3'b010, 32'h100, 32'h0, 0, 0);
    // signed / unsigned byte at 0x200
    txn(0, 1, 3'b000, 32'h200, 32'h0000_0080, 0, 0);
    txn(0, 0, 3'b000, 32'h200, 32'h0, 0, 0);
    txn(0, 0, 3'b100, 32'h200, 32'h0, 0, 0);
    // half store and signed half load
    txn(0, 1, 3'b001, 32'h300, 32'hDEAD_BEEF, 0, 0);
    txn(0, 0, 3'b001, 32'h300, 32'h0, 0, 0);

    // arbitration: both requests in the same cycle, LSB served first
    @(posedge clk); #1;
    lsb_req = 1'b1; lsb_way = 1'b0; lsb_size = 3'b000; lsb_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h500;
    @(posedge clk); #1;
    lsb_req = 1'b0;
    @(negedge clk);
    check("arb_lsb_a", mem_a, 32'h200);
    @(negedge clk);
    check("arb_lsb_rdy", 32'(lsb_ready), 32'h1);
    check("arb_lsb_res", lsb_result, 32'hFFFF_FF80);
    check("arb_no_accept_in_rdy", mem_a, 32'h0);
    @(negedge clk);
    check("arb_if_pending", mem_a, 32'h0);
    @(posedge clk); #1;
    if_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("arb_if_a", mem_a, 32'h500 + 32'(k));
    end
    @(negedge clk);
    check("arb_if_rdy", 32'(if_ready), 32'h1);
    check("arb_if_inst", if_inst, ref_load(32'h500, 4, 1'b1));

    // flush: fetch aborted in its second cycle; clear blocks a new fetch
    txn(1, 0, 3'b010, 32'h600, 32'h0, 2, 0);
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h640; clear = 1'b1;
    @(posedge clk); #1;
    if_req = 1'b0; clear = 1'b0;
    @(negedge clk);
    check("clear_blocks_if", mem_a, 32'h0);
    // clear during a store is ignored
    txn(0, 1, 3'b010, 32'h700, $urandom, 2, 0);
    txn(0, 0, 3'b010, 32'h700, 32'h0, 0, 0);
    // rdy freeze mid-store
    txn(0, 1, 3'b010, 32'h740, $urandom, 0, 3);
    txn(0, 0, 3'b110, 32'h740, 32'h0, 0, 0);

    // IO store with the UART buffer full
`ifdef MEM_CTRL_IO_STALL_EN
    @(posedge clk); #1;
    io_buffer_full = 1'b1;
    lsb_req = 1'b1; lsb_way = 1'b1; lsb_size = 3'b000; lsb_addr = 32'h3_0000; lsb_value = 32'h41;
    @(posedge clk); #1;
    lsb_req = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("io_stall_wr", 32'(mem_wr), 32'h0);
      @(posedge clk); #1;
    end
    io_buffer_full = 1'b0;
    @(negedge clk);
    check("io_wr", 32'(mem_wr), 32'h1);
    check("io_a", mem_a, 32'h3_0000);
    check("io_dout", 32'(mem_dout), 32'h41);
    @(negedge clk);
    check("io_rdy", 32'(lsb_ready), 32'h1);
    ref_mem[0] = 8'h41;
`else
    io_buffer_full = 1'b1;
    txn(0, 1, 3'b000, 32'h3_0000, 32'h41, 0, 0);
    io_buffer_full = 1'b0;
`endif
    txn(0, 0, 3'b100, 32'h0, 32'h0, 0, 0);

    // randomized traffic against the reference image
    for (int r = 0; r < 40; r++) begin
      bit is_if, way, ext;
      logic [1:0] sz;
      int clr, frz;
      is_if = ($urandom_range(0, 3) == 0);
      way   = 1'($urandom_range(0, 1));
      ext   = 1'($urandom_range(0, 1));
      sz    = 2'($urandom_range(0, 2));
      clr   = (!is_if && way) ? $urandom_range(0, 1) : 0;
      frz   = (!is_if && way && $urandom_range(0, 3) == 0) ? 1 : 0;
      v     = $urandom;
      txn(is_if, way, {ext, sz}, 32'h100 + $urandom_range(0, 32'hE00), v, clr, frz);
    end

    // reset in the middle of a word store
    txn(1, 0, 3'b010, 32'h100, 32'h0, 0, 0);
    txn(0, 0, 3'b010, 32'h100, 32'h0, 0, 0);
    @(posedge clk); #1;
    lsb_req = 1'b1; lsb_way = 1'b1; lsb_size = 3'b010; lsb_addr = 32'h400; lsb_value = $urandom;
    @(posedge clk); #1;
    lsb_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("pre_rst_a", mem_a, 32'h401);
    @(posedge clk); #1;
    rst = 1'b0;
    ref_reset();
    @(negedge clk);
    check("midrst_wr", 32'(mem_wr), 32'h0);
    check("midrst_a", mem_a, 32'h0);
    check("midrst_dout", 32'(mem_dout), 32'h0);
    check("midrst_rdy", 32'({if_ready, lsb_ready}), 32'h0);
    check("midrst_inst", if_inst, 32'h0);
    check("midrst_res", lsb_result, 32'h0);
    check("midrst_state", 32'(fsm_state), 32'(MC_IDLE));
    txn(0, 0, 3'b010, 32'h400, 32'h0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
